// File: rtl/regfile_arbiter_2r_if.sv
// Bus shared by the two requesters, the arbiter and the register file A/C ports.
// werr exists only when REGFILE_ARB_R0_WPROT_EN is defined.
interface regfile_arbiter_2r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] a_select;
    logic [DATA_W-1:0] a_data;
    logic [ADDR_W-1:0] c_select;
    logic [DATA_W-1:0] c_data;
    logic              write;
`ifdef REGFILE_ARB_R0_WPROT_EN
    logic              werr;
`endif

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  a_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output a_select, c_select, c_data, write
`ifdef REGFILE_ARB_R0_WPROT_EN
        , output werr
`endif
    );

    // Requester / register file side.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output a_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  a_select, c_select, c_data, write
`ifdef REGFILE_ARB_R0_WPROT_EN
        , input werr
`endif
    );
endinterface

// File: rtl/regfile_arbiter_2r.sv
// Two-requester arbiter for the register file A-read / C-write ports, one access per 2 cycles.
// Optional macro REGFILE_ARB_R0_WPROT_EN blocks writes to R0 and flags them on werr.
module regfile_arbiter_2r #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 in_clk,
    input  logic                 in_clr,
    regfile_arbiter_2r_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              grant;
    logic              win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // last_gnt points at the most recent winner; op_id is the owner of the op in flight.
    logic              last_gnt;
    logic              op_id;

    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] a_select_q;
    logic [ADDR_W-1:0] c_select_q;
    logic [DATA_W-1:0] c_data_q;
`ifdef REGFILE_ARB_R0_WPROT_EN
    logic              werr_q;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        next_state = state;
        grant      = 1'b0;
        win_id     = 1'b0;
        win_we     = 1'b0;
        win_addr   = '0;
        win_wdata  = '0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant = 1'b1;
                    if (bus.req0 && bus.req1) begin
                        win_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
                    end else begin
                        win_id = bus.req1;
                    end
                    win_we     = win_id ? bus.we1    : bus.we0;
                    win_addr   = win_id ? bus.addr1  : bus.addr0;
                    win_wdata  = win_id ? bus.wdata1 : bus.wdata0;
                    next_state = win_we ? WRITE : READ;
                end
            end
            READ:    next_state = IDLE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_clr) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            op_id      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
            a_select_q <= '0;
            c_select_q <= '0;
            c_data_q   <= '0;
`ifdef REGFILE_ARB_R0_WPROT_EN
            werr_q     <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= next_state;
            gnt0_q    <= grant & ~win_id;
            gnt1_q    <= grant &  win_id;
            rvalid0_q <= (state == READ) & ~op_id;
            rvalid1_q <= (state == READ) &  op_id;
            if (state == READ) begin
                rdata_q <= bus.a_data;
            end
            // The select/data registers double as the latched op and hold outside their state.
            if (grant) begin
                last_gnt <= win_id;
                op_id    <= win_id;
                if (win_we) begin
                    c_select_q <= win_addr;
                    c_data_q   <= win_wdata;
                end else begin
                    a_select_q <= win_addr;
                end
            end
`ifdef REGFILE_ARB_R0_WPROT_EN
            werr_q <= grant & win_we & (win_addr == '0);
`endif
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata    = rdata_q;
    assign bus.a_select = a_select_q;
    assign bus.c_select = c_select_q;
    assign bus.c_data   = c_data_q;

    // Gated by in_clr combinationally so a reset landing in WRITE never reaches the file.
`ifdef REGFILE_ARB_R0_WPROT_EN
    assign bus.write = (state == WRITE) & in_clr & (c_select_q != '0);
    assign bus.werr  = werr_q;
`else
    assign bus.write = (state == WRITE) & in_clr;
`endif

endmodule

// File: tb/tb_regfile_arbiter_2r.sv
// Self-checking bench: directed cases plus randomized two-requester traffic against a
// transaction-level schedule model; a second FIXED_PRIO=1 instance covers fixed priority.
module tb_regfile_arbiter_2r;

    localparam int DW = 32;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_arbiter_2r_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_arbiter_2r_if #(.DATA_W(DW), .ADDR_W(AW)) pbus ();

    regfile_arbiter_2r #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0)) dut (
        .in_clk (clk),
        .in_clr (rst_n),
        .bus    (bus)
    );

    regfile_arbiter_2r #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1)) dut_p (
        .in_clk (clk),
        .in_clr (rst_n),
        .bus    (pbus)
    );

    // The fixed-priority instance sees the same requests and a dummy register file.
    assign pbus.req0   = bus.req0;
    assign pbus.we0    = bus.we0;
    assign pbus.addr0  = bus.addr0;
    assign pbus.wdata0 = bus.wdata0;
    assign pbus.req1   = bus.req1;
    assign pbus.we1    = bus.we1;
    assign pbus.addr1  = bus.addr1;
    assign pbus.wdata1 = bus.wdata1;
    assign pbus.a_data = '0;

    // Register file attached to the main instance.
    logic [DW-1:0] rf [16];
    assign bus.a_data = rf[bus.a_select];
    always @(posedge clk) if (bus.write) rf[bus.c_select] <= bus.c_data;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted op schedules its future observable events into slots indexed by cycle.
    int          cyc      = 0;
    bit          model_on = 1'b0;
    int          free_at  = 0;
    bit          m_last   = 1'b1;
    bit          e_gnt0 [4];
    bit          e_gnt1 [4];
    bit          e_rv0  [4];
    bit          e_rv1  [4];
    bit          e_wr   [4];
    int          e_raddr[4];
    logic [31:0] m_regs [16];
    logic [31:0] exp_rdata = '0;
    logic [3:0]  exp_asel  = '0;
    logic [3:0]  exp_csel  = '0;
    logic [31:0] exp_cdat  = '0;

    always @(posedge clk) begin
        bit          w;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] data;
        if (!rst_n) begin
            model_on = 1'b1;
            for (int i = 0; i < 4; i++) begin
                e_gnt0[i] = 0; e_gnt1[i] = 0; e_rv0[i] = 0; e_rv1[i] = 0; e_wr[i] = 0;
            end
            free_at   = cyc + 1;
            m_last    = 1'b1;
            exp_rdata = '0;
            exp_asel  = '0;
            exp_csel  = '0;
            exp_cdat  = '0;
        end else if (model_on && cyc >= free_at && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
            else                      w = bus.req1;
            we   = w ? bus.we1    : bus.we0;
            addr = w ? bus.addr1  : bus.addr0;
            data = w ? bus.wdata1 : bus.wdata0;
            if (w) e_gnt1[(cyc + 1) % 4] = 1;
            else   e_gnt0[(cyc + 1) % 4] = 1;
            if (we) begin
                e_wr[(cyc + 1) % 4] = 1;
                exp_csel = addr;
                exp_cdat = data;
            end else begin
                if (w) e_rv1[(cyc + 2) % 4] = 1;
                else   e_rv0[(cyc + 2) % 4] = 1;
                e_raddr[(cyc + 2) % 4] = int'(addr);
                exp_asel = addr;
            end
            free_at = cyc + 2;
            m_last  = w;
        end
        cyc++;
    end

    // One compare process, every cycle after the first reset edge.
    always @(negedge clk) begin
        int s;
        bit exp_wr;
        if (model_on) begin
            s = cyc % 4;
`ifdef REGFILE_ARB_R0_WPROT_EN
            exp_wr = e_wr[s] && rst_n && (exp_csel != 4'd0);
            check("werr", 32'(bus.werr), 32'(e_wr[s] && exp_csel == 4'd0));
`else
            exp_wr = e_wr[s] && rst_n;
`endif
            check("gnt0",    32'(bus.gnt0),    32'(e_gnt0[s]));
            check("gnt1",    32'(bus.gnt1),    32'(e_gnt1[s]));
            check("rvalid0", 32'(bus.rvalid0), 32'(e_rv0[s]));
            check("rvalid1", 32'(bus.rvalid1), 32'(e_rv1[s]));
            check("write",   32'(bus.write),   32'(exp_wr));
            if (exp_wr) m_regs[exp_csel] = exp_cdat;
            if (e_rv0[s] || e_rv1[s]) exp_rdata = m_regs[e_raddr[s]];
            check("rdata",    bus.rdata,           exp_rdata);
            check("a_select", 32'(bus.a_select),   32'(exp_asel));
            check("c_select", 32'(bus.c_select),   32'(exp_csel));
            check("c_data",   bus.c_data,          exp_cdat);
            e_gnt0[s] = 0; e_gnt1[s] = 0; e_rv0[s] = 0; e_rv1[s] = 0; e_wr[s] = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_op0;
        bus.we0    = 1'($urandom_range(0, 1));
        bus.addr0  = 4'($urandom_range(0, 15));
        bus.wdata0 = $urandom;
        bus.req0   = 1'b1;
    endtask

    task automatic new_op1;
        bus.we1    = 1'($urandom_range(0, 1));
        bus.addr1  = 4'($urandom_range(0, 15));
        bus.wdata1 = $urandom;
        bus.req1   = 1'b1;
    endtask

    initial begin
        int wait0;
        int wait1;
        for (int i = 0; i < 16; i++) begin
            rf[i]     = 32'hA0A0_0000 | 32'(i);
            m_regs[i] = 32'hA0A0_0000 | 32'(i);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd7; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 4'd0; bus.wdata1 = '0;

        // Reset held two cycles with a pending request.
        for (int i = 0; i < 2; i++) begin
            tick;
            check("rst_gnt0",   32'(bus.gnt0),     32'd0);
            check("rst_rvalid", 32'(bus.rvalid0),  32'd0);
            check("rst_write",  32'(bus.write),    32'd0);
            check("rst_rdata",  bus.rdata,         32'd0);
            check("rst_asel",   32'(bus.a_select), 32'd0);
        end
        bus.req0 = 1'b0;
        rst_n    = 1'b1;
        tick;

        // Continuous tie: round-robin alternates 0,1,0,1; fixed priority serves only 0.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
        for (int i = 1; i <= 8; i++) begin
            tick;
            check("tie_rr_gnt0", 32'(bus.gnt0),  32'(i % 4 == 1));
            check("tie_rr_gnt1", 32'(bus.gnt1),  32'(i % 4 == 3));
            check("tie_fp_gnt0", 32'(pbus.gnt0), 32'(i % 2 == 1));
            check("tie_fp_gnt1", 32'(pbus.gnt1), 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("tie_rdata", bus.rdata, 32'hA0A0_0002);
        tick;
        tick;

        // Write R5 then read it back through requester 0.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 32'h1111_0000;
        tick;
        check("wr_gnt0",  32'(bus.gnt0),     32'd1);
        check("wr_write", 32'(bus.write),    32'd1);
        check("wr_csel",  32'(bus.c_select), 32'd5);
        check("wr_cdata", bus.c_data,        32'h1111_0000);
        tick;
        check("wr_write_end", 32'(bus.write), 32'd0);
        bus.we0 = 1'b0;
        tick;
        check("rd_gnt0", 32'(bus.gnt0),     32'd1);
        check("rd_asel", 32'(bus.a_select), 32'd5);
        tick;
        check("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("rd_rdata",   bus.rdata,        32'h1111_0000);
        bus.req0 = 1'b0;
        tick;
        check("rd_rvalid0_end", 32'(bus.rvalid0), 32'd0);
        check("rd_rdata_hold",  bus.rdata,         32'h1111_0000);

        // Reset during the WRITE cycle suppresses the write to R3.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 32'hDEAD_BEEF;
        tick;
        check("rstw_gnt0", 32'(bus.gnt0), 32'd1);
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        #1;
        check("rstw_write", 32'(bus.write), 32'd0);
        tick;
        rst_n    = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd3;
        tick;
        tick;
        check("rstw_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("rstw_r3",      bus.rdata,        32'hA0A0_0003);
        bus.req0 = 1'b0;
        tick;

`ifdef REGFILE_ARB_R0_WPROT_EN
        // Protected write to R0: granted, flagged, not performed.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd0; bus.wdata0 = 32'h1111_1111;
        tick;
        check("wp_gnt0",  32'(bus.gnt0),  32'd1);
        check("wp_write", 32'(bus.write), 32'd0);
        check("wp_werr",  32'(bus.werr),  32'd1);
        tick;
        check("wp_werr_end", 32'(bus.werr), 32'd0);
        bus.we0 = 1'b0;
        tick;
        tick;
        check("wp_r0", bus.rdata, 32'hA0A0_0000);
        bus.req0 = 1'b0;
        tick;
`endif

        // Randomized traffic with occasional resets.
        wait0 = 0;
        wait1 = 0;
        for (int n = 0; n < 800; n++) begin
            tick;
            if (!rst_n)                           rst_n = 1'b1;
            else if ($urandom_range(0, 79) == 0)  rst_n = 1'b0;

            if (bus.req0 && bus.gnt0) begin
                wait0 = 0;
                if ($urandom_range(0, 1) == 1) new_op0;
                else                           bus.req0 = 1'b0;
            end else if (!bus.req0) begin
                if ($urandom_range(0, 2) == 0) new_op0;
            end else begin
                wait0++;
                if (wait0 > 12) begin
                    check("starve0", 32'(wait0), 32'd12);
                    bus.req0 = 1'b0;
                    wait0    = 0;
                end
            end

            if (bus.req1 && bus.gnt1) begin
                wait1 = 0;
                if ($urandom_range(0, 1) == 1) new_op1;
                else                           bus.req1 = 1'b0;
            end else if (!bus.req1) begin
                if ($urandom_range(0, 2) == 0) new_op1;
            end else begin
                wait1++;
                if (wait1 > 12) begin
                    check("starve1", 32'(wait1), 32'd12);
                    bus.req1 = 1'b0;
                    wait1    = 0;
                end
            end
        end
        rst_n    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (4) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
